data_mem_responder: RTL and testbench

//  Data-side memory responder for the 5-stage RISC-V pipeline core. Answers the core's M-stage

---
 rtl/data_mem_responder_pkg.sv | 19 +
 rtl/data_mem_responder_io_tx_fifo.sv | 58 +++++
 rtl/data_mem_responder.sv | 107 ++++++++++
 tb/tb_data_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-side memory responder: IO region select bit,
// IO register offsets and the STATUS word packing helper.
package riscv_mem_pkg;

  localparam int          IO_BIT        = 22;
  localparam logic [2:0]  IO_OFF_TX     = 3'd0;
  localparam logic [2:0]  IO_OFF_STATUS = 3'd1;
  localparam logic [2:0]  IO_OFF_CYCLE  = 3'd2;
  localparam logic [2:0]  IO_OFF_CLR    = 3'd3;
  localparam logic [31:0] IO_BASE       = 32'h0040_0000;

  // STATUS register layout: {29'b0, overflow, full, empty}
  function automatic logic [31:0] pack_status(input logic overflow,
                                              input logic full,
                                              input logic empty);
    return {29'b0, overflow, full, empty};
  endfunction

endpackage

// File: rtl/data_mem_responder_io_tx_fifo.sv
// Small synchronous FIFO buffering words the core emits on the TX channel.
// The head is read straight from storage, so outputs depend only on
// registered state. A push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module io_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = storage[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Capture accepted pushes; when full+pop this overwrites the slot being popped.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder for the pipelined core: word RAM plus a small
// IO region (TX FIFO, status, cycle counter, overflow clear) selected by
// one address bit. Reads are combinational so the core can latch them at
// the next clock edge.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int    ADDR_W     = 12,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [31:0] io_out_data,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic        io_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [2**ADDR_W];
  logic              is_io;
  logic [2:0]        io_off;
  logic [ADDR_W-1:0] word_idx;
  logic              tx_push;
  logic              clr_write;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;
  logic [31:0]       cycle_cnt;
  logic              unused_addr;

  assign is_io       = Address[IO_BIT];
  assign io_off      = Address[4:2];
  assign word_idx    = Address[ADDR_W+1:2];
  assign unused_addr = ^{Address[31:IO_BIT+1], Address[IO_BIT-1:ADDR_W+2], Address[1:0]};

  assign tx_push   = MemWrite && is_io && (io_off == IO_OFF_TX);
  assign clr_write = MemWrite && is_io && (io_off == IO_OFF_CLR);
  assign tx_pop    = io_out_valid && io_out_ready;

  assign io_out_valid = !tx_empty;

  // Full-word stores into RAM; IO-region stores never reach the array.
  always_ff @(posedge clk) begin
    if (MemWrite && !is_io) begin
      ram[word_idx] <= WriteData;
    end
  end

  io_tx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (WriteData),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (io_out_data)
  );

  // Sticky overflow: set by a dropped push, cleared only by a CLR store or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_overflow <= 1'b0;
    end else if (clr_write) begin
      io_overflow <= 1'b0;
    end else if (tx_push && tx_full && !tx_pop) begin
      io_overflow <= 1'b1;
    end
  end

  // Free-running cycle counter for program self-timing; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Zero-latency read mux; a same-cycle store is not visible until after the edge.
  always_comb begin
    ReadData = 32'h0;
    if (is_io) begin
      unique case (io_off)
        IO_OFF_TX:     ReadData = 32'(tx_count);
        IO_OFF_STATUS: ReadData = pack_status(io_overflow, tx_full, tx_empty);
        IO_OFF_CYCLE:  ReadData = cycle_cnt;
        default:       ReadData = 32'h0;
      endcase
    end else begin
      ReadData = ram[word_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized traffic, all checked against a queue/array reference model.
module tb_data_mem_responder;

  localparam int ADDR_W     = 12;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] IO_A     = 32'h0040_0000;
  localparam logic [31:0] TX_A     = IO_A + 32'h0;
  localparam logic [31:0] STATUS_A = IO_A + 32'h4;
  localparam logic [31:0] CYCLE_A  = IO_A + 32'h8;
  localparam logic [31:0] CLR_A    = IO_A + 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [31:0] io_out_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic        io_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] q_m [$];
  logic        ovf_m;
  logic [31:0] cyc_m;

  data_mem_responder #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .INIT_FILE  ("")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .WriteData    (WriteData),
    .MemWrite     (MemWrite),
    .ReadData     (ReadData),
    .io_out_data  (io_out_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_overflow  (io_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected ReadData for an address; returns 0 when the model has no value.
  function automatic bit modelRead(input logic [31:0] a, output logic [31:0] v);
    int idx;
    v = 32'h0;
    if (a[22]) begin
      case (a[4:2])
        3'd0: v = 32'(q_m.size());
        3'd1: v = {29'b0, ovf_m, q_m.size() == FIFO_DEPTH, q_m.size() == 0};
        3'd2: v = cyc_m;
        default: v = 32'h0;
      endcase
      return 1'b1;
    end
    idx = int'(a[ADDR_W+1:2]);
    if (!ram_m.exists(idx)) return 1'b0;
    v = ram_m[idx];
    return 1'b1;
  endfunction

  // Drive one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd,
                               input logic we, input logic rdy, input string tag);
    logic [31:0] exp_rd;
    bit          known;
    Address      = a;
    WriteData    = wd;
    MemWrite     = we;
    io_out_ready = rdy;
    #1;
    checkOutput({tag, ":valid"}, {31'b0, io_out_valid}, {31'b0, q_m.size() != 0});
    if (q_m.size() != 0) checkOutput({tag, ":data"}, io_out_data, q_m[0]);
    checkOutput({tag, ":ovf"}, {31'b0, io_overflow}, {31'b0, ovf_m});
    known = modelRead(a, exp_rd);
    if (known) checkOutput({tag, ":rd"}, ReadData, exp_rd);
    @(posedge clk);
    if (q_m.size() != 0 && rdy) void'(q_m.pop_front());
    if (we && a[22]) begin
      if (a[4:2] == 3'd0) begin
        if (q_m.size() < FIFO_DEPTH) q_m.push_back(wd);
        else ovf_m = 1'b1;
      end else if (a[4:2] == 3'd3) begin
        ovf_m = 1'b0;
      end
    end else if (we) begin
      ram_m[int'(a[ADDR_W+1:2])] = wd;
    end
    cyc_m = cyc_m + 32'd1;
    @(negedge clk);
  endtask

  // Assert reset part-way through a cycle, check immediate effects, release at negedge.
  task automatic pulseReset(input string tag);
    MemWrite = 1'b0;
    Address  = TX_A;
    #2;
    reset = 1'b1;
    #1;
    checkOutput({tag, ":rst_valid"}, {31'b0, io_out_valid}, 32'h0);
    checkOutput({tag, ":rst_count"}, ReadData, 32'h0);
    q_m.delete();
    ovf_m = 1'b0;
    cyc_m = 32'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    reset        = 1'b1;
    Address      = CYCLE_A;
    WriteData    = 32'h0;
    MemWrite     = 1'b0;
    io_out_ready = 1'b0;
    ovf_m        = 1'b0;
    cyc_m        = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset:valid", {31'b0, io_out_valid}, 32'h0);
    checkOutput("reset:ovf", {31'b0, io_overflow}, 32'h0);
    checkOutput("reset:cycle", ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] RAM store/read and persistence across reset");
    applyStimulus(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, "t1_wr");
    applyStimulus(32'h10, 32'h0, 1'b0, 1'b0, "t1_rd");
    pulseReset("t1");
    Address = 32'h10;
    #1;
    checkOutput("t1:after_reset", ReadData, 32'hDEAD_BEEF);
    applyStimulus(32'h14, 32'h1111_2222, 1'b1, 1'b0, "t1_same_cycle_old");
    applyStimulus(32'h14, 32'h3333_4444, 1'b1, 1'b0, "t1_overwrite");
    applyStimulus(32'h14 | 32'h0012_0000, 32'h0, 1'b0, 1'b0, "t1_alias");

    $display("[TB] single TX push and IO reads");
    applyStimulus(TX_A, 32'h41, 1'b1, 1'b0, "t2_push");
    #1;
    checkOutput("t2:valid", {31'b0, io_out_valid}, 32'h1);
    checkOutput("t2:data", io_out_data, 32'h41);
    applyStimulus(STATUS_A, 32'h0, 1'b0, 1'b0, "t2_status");
    Address = TX_A;
    #1;
    checkOutput("t2:count", ReadData, 32'h1);
    applyStimulus(TX_A, 32'h0, 1'b0, 1'b1, "t2_drain");

    $display("[TB] overflow, drain order, clear");
    for (int i = 1; i <= 5; i++) applyStimulus(TX_A, 32'(i), 1'b1, 1'b0, "t3_push");
    Address = STATUS_A;
    #1;
    checkOutput("t3:status", ReadData, 32'h6);
    checkOutput("t3:ovf", {31'b0, io_overflow}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      Address      = STATUS_A;
      io_out_ready = 1'b1;
      #1;
      checkOutput("t3:drain", io_out_data, 32'(i));
      applyStimulus(STATUS_A, 32'h0, 1'b0, 1'b1, "t3_drain");
    end
    applyStimulus(CLR_A, 32'h0, 1'b1, 1'b0, "t3_clr");
    #1;
    checkOutput("t3:ovf_clr", {31'b0, io_overflow}, 32'h0);

    $display("[TB] push into full FIFO with simultaneous pop");
    for (int i = 1; i <= 4; i++) applyStimulus(TX_A, 32'(i), 1'b1, 1'b0, "t4_fill");
    applyStimulus(TX_A, 32'h9, 1'b1, 1'b1, "t4_push_pop");
    Address = TX_A;
    #1;
    checkOutput("t4:head", io_out_data, 32'h2);
    checkOutput("t4:count", ReadData, 32'h4);
    checkOutput("t4:ovf", {31'b0, io_overflow}, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(STATUS_A, 32'h0, 1'b0, 1'b1, "t4_drain");

    $display("[TB] cycle counter");
    pulseReset("t5");
    for (int i = 0; i < 100; i++) applyStimulus(STATUS_A, 32'h0, 1'b0, 1'b0, "t5_idle");
    Address = CYCLE_A;
    #1;
    checkOutput("t5:cycle100", ReadData, 32'd100);
    @(negedge clk);
    cyc_m = cyc_m + 32'd1;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    cyc_m = 32'hFFFF_FFFF;
    applyStimulus(CYCLE_A, 32'h0, 1'b0, 1'b0, "t5_max");
    applyStimulus(CYCLE_A, 32'h0, 1'b0, 1'b0, "t5_wrap");

    $display("[TB] reset with entries queued");
    for (int i = 0; i < 3; i++) applyStimulus(TX_A, 32'hA0 + 32'(i), 1'b1, 1'b0, "t6_fill");
    pulseReset("t6");
    applyStimulus(TX_A, 32'h77, 1'b1, 1'b0, "t6_push");
    #1;
    checkOutput("t6:head", io_out_data, 32'h77);
    applyStimulus(TX_A, 32'h0, 1'b0, 1'b1, "t6_drain");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 8; i++) applyStimulus(32'(i) << 2, $urandom, 1'b1, 1'b0, "rnd_init");
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      a  = (($urandom & 32'hFFBF_C000) | (32'($urandom_range(0, 7)) << 2));
      d  = $urandom;
      case (op)
        0, 1:    applyStimulus(a, d, 1'b1, 1'($urandom_range(0, 1)), "rnd_ramwr");
        2, 3:    applyStimulus(a, d, 1'b0, 1'($urandom_range(0, 1)), "rnd_ramrd");
        4, 5:    applyStimulus(TX_A, d, 1'b1, 1'($urandom_range(0, 1)), "rnd_push");
        6:       applyStimulus(CLR_A, d, 1'b1, 1'($urandom_range(0, 1)), "rnd_clr");
        7:       applyStimulus(IO_A | (32'($urandom_range(0, 7)) << 2), d, 1'b0,
                               1'($urandom_range(0, 1)), "rnd_iord");
        8:       applyStimulus(IO_A | (32'($urandom_range(4, 7)) << 2), d, 1'b1,
                               1'($urandom_range(0, 1)), "rnd_iowr_ign");
        default: applyStimulus(STATUS_A, d, 1'b0, 1'($urandom_range(0, 1)), "rnd_idle");
      endcase
    end
    for (int i = 0; i < 8; i++) applyStimulus(32'(i) << 2, 32'h0, 1'b0, 1'b1, "rnd_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
